// File: rtl/fetch_queue_unit_pkg.sv
// Shared constants for the instruction-fetch front end.
// No logic; reset PC default, SRAM latency, PC step and the empty-slot instruction.
package fetch_queue_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0;
    localparam int          IMEM_READ_LATENCY = 1;
    localparam int          PC_INCR           = 4;
    localparam logic [31:0] NOP_INSTR         = 32'h0;

endpackage

// File: rtl/fetch_queue_unit_sync_fifo.sv
// Circular buffer with flush; head is combinational from the read pointer (0-cycle read).
// No internal backpressure: the owner must never push when full without popping in the same cycle.
module sync_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    input  logic [DATA_W-1:0]           wr_data_i,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic [DATA_W-1:0]           head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch PC owner: issues SRAM reads, absorbs the 1-cycle read latency, queues {instr, pc+4} for decode.
// First word reaches id_valid 2 cycles after issue; issue stalls when queued + inflight words fill DEPTH.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int               DATA_W   = 32,
    parameter int               DEPTH    = 4,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              redirect,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] imem_addr,
    output logic              imem_ren,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instruction,
    output logic [DATA_W-1:0] id_updated_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic                inflight_q, inflight_d;
    logic [DATA_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic [CW-1:0]       count;
    logic [2*DATA_W-1:0] head;
    logic                redir_go;
    logic                issue;
    logic                push;
    logic                pop;

    // The inflight slot is reserved up front, so a push can never find the queue full.
    assign issue    = enable & ~redirect & ((count + CW'(inflight_q)) < CW'(DEPTH));
    assign redir_go = enable & redirect;
    assign push     = inflight_q & ~redir_go;
    assign pop      = enable & id_valid & id_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redir_go) begin
            fetch_pc_d = redirect_pc & ~DATA_W'(3);
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + DATA_W'(PC_INCR);
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    sync_fifo #(
        .DATA_W (2 * DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .push_i    (push),
        .pop_i     (pop),
        .flush_i   (redir_go),
        .wr_data_i ({imem_rdata, inflight_pc_q + DATA_W'(PC_INCR)}),
        .count_o   (count),
        .head_o    (head)
    );

    // Gate with reset so the SRAM sees no request while the unit is held in reset.
    assign imem_ren       = issue & arst_n;
    assign imem_addr      = fetch_pc_q;
    assign id_valid       = (count != '0);
    assign id_instruction = id_valid ? head[2*DATA_W-1:DATA_W] : DATA_W'(NOP_INSTR);
    assign id_updated_pc  = id_valid ? head[DATA_W-1:0] : '0;

endmodule
